// File: rtl/sr_ctrl_pkg.sv
// Shared types and helpers for the serial shift-register transfer controller.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int MAX_GAP = 15;
    localparam int GAP_CW  = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sr_shift_core.sv
// WIDTH-bit shift register with parallel load and a selectable shift direction.
module sr_shift_core #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] shreg;

    // Value the register takes on a shift, with sin already inserted.
    always_comb begin
        if (MSB_FIRST != 0) shifted = {shreg[WIDTH-2:0], sin};
        else                shifted = {sin, shreg[WIDTH-1:1]};
    end

    assign sout = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        shreg <= '0;
        else if (load)     shreg <= load_data;
        else if (shift_en) shreg <= shifted;
    end

endmodule

// File: rtl/sr_serial_xfer_ctrl.sv
// Sequences WIDTH-bit serial transfers: valid/ready word intake, framed shift-out, parallel capture.
// Handshake: a word transfers on the posedge where tx_valid and tx_ready are both 1; rx_valid is a
// single-cycle pulse with no back-pressure.
module sr_serial_xfer_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             sin,
    output logic             sout,
    output logic             sen,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP == 0) ? 0 : GAP - 1);

    state_e            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [GAP_CW-1:0] gap_cnt;
    logic              last_bit;
    logic              load;
    logic [WIDTH-1:0]  load_data;
    logic              shift_en;
    logic [WIDTH-1:0]  shifted;

    assign last_bit  = (state == ST_SHIFT) && (cnt == CNT_LAST);
    assign tx_ready  = (state == ST_IDLE) || (last_bit && (GAP == 0));
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Leaving SHIFT without a new word loads zeros so sout idles low straight from the register.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_data = tx_data;
        shift_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    shift_en = 1'b1;
                end else if (GAP > 0) begin
                    load      = 1'b1;
                    load_data = '0;
                    state_nxt = ST_GAP;
                end else if (tx_valid) begin
                    load = 1'b1;
                end else begin
                    load      = 1'b1;
                    load_data = '0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            gap_cnt  <= '0;
            sen      <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            sen      <= (state_nxt == ST_SHIFT);
            rx_valid <= last_bit;
            if (last_bit) rx_data <= shifted;
            if (state == ST_SHIFT && !last_bit) cnt <= cnt + 1'b1;
            else                                cnt <= '0;
            if (state == ST_GAP && state_nxt == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                                        gap_cnt <= '0;
        end
    end

    sr_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .shift_en  (shift_en),
        .sin       (sin),
        .sout      (sout),
        .shifted   (shifted)
    );

endmodule

// File: tb/tb_sr_serial_xfer_ctrl.sv
// Directed bench: default loopback instance, GAP=2 loopback instance, LSB-first instance with sin tied high.
module tb_sr_serial_xfer_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // instance a: defaults, loopback
    logic [7:0] tx_data_a;
    logic       tx_valid_a, tx_ready_a, sout_a, sen_a, rx_valid_a, busy_a;
    logic [7:0] rx_data_a;
    logic [1:0] dbg_a;
    // instance g: GAP=2, loopback
    logic [7:0] tx_data_g;
    logic       tx_valid_g, tx_ready_g, sout_g, sen_g, rx_valid_g, busy_g;
    logic [7:0] rx_data_g;
    logic [1:0] dbg_g;
    // instance l: LSB first, sin tied 1
    logic [7:0] tx_data_l;
    logic       tx_valid_l, tx_ready_l, sout_l, sen_l, rx_valid_l, busy_l;
    logic [7:0] rx_data_l;
    logic [1:0] dbg_l;
    logic       sin_l;

    assign sin_l = 1'b1;

    sr_serial_xfer_ctrl u_dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .sin(sout_a), .sout(sout_a), .sen(sen_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .busy(busy_a), .dbg_state(dbg_a)
    );

    sr_serial_xfer_ctrl #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) u_dut_g (
        .clk(clk), .reset(reset), .tx_data(tx_data_g), .tx_valid(tx_valid_g), .tx_ready(tx_ready_g),
        .sin(sout_g), .sout(sout_g), .sen(sen_g), .rx_data(rx_data_g), .rx_valid(rx_valid_g),
        .busy(busy_g), .dbg_state(dbg_g)
    );

    sr_serial_xfer_ctrl #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) u_dut_l (
        .clk(clk), .reset(reset), .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready_l),
        .sin(sin_l), .sout(sout_l), .sen(sen_l), .rx_data(rx_data_l), .rx_valid(rx_valid_l),
        .busy(busy_l), .dbg_state(dbg_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tx_data_a = 8'h5A; tx_data_g = 8'h5A; tx_data_l = 8'h5A;
        tx_valid_a = 1'b1; tx_valid_g = 1'b1; tx_valid_l = 1'b1;
        tick();
        tick();
        total++; if (sout_a !== 1'b0) begin bad++; $display("FAIL reset_sout got=%b exp=0", sout_a); end
        total++; if (sen_a !== 1'b0) begin bad++; $display("FAIL reset_sen got=%b exp=0", sen_a); end
        total++; if (rx_valid_a !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid_a); end
        total++; if (rx_data_a !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready_a); end
        total++; if ({sen_g, sen_l, busy_g, busy_l} !== 4'b0000) begin
            bad++; $display("FAIL reset_other got=%b exp=0000", {sen_g, sen_l, busy_g, busy_l});
        end
        reset = 1'b1;
        tx_valid_a = 1'b0; tx_valid_g = 1'b0; tx_valid_l = 1'b0;
        tick();
        total++; if ({busy_a, busy_g, busy_l} !== 3'b000) begin
            bad++; $display("FAIL reset_no_accept busy got=%b exp=000", {busy_a, busy_g, busy_l});
        end
    endtask

    task automatic test_loopback_msb();
        logic [7:0] word;
        word = 8'hA5;
        tx_data_a = word;
        tx_valid_a = 1'b1;
        total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL lb_ready got=%b exp=1", tx_ready_a); end
        tick();
        tx_valid_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (sout_a !== word[7-i]) begin bad++; $display("FAIL lb_sout bit%0d got=%b exp=%b", i, sout_a, word[7-i]); end
            total++; if (sen_a !== 1'b1) begin bad++; $display("FAIL lb_sen bit%0d got=%b exp=1", i, sen_a); end
            total++; if (rx_valid_a !== 1'b0) begin bad++; $display("FAIL lb_early_rx_valid bit%0d got=%b exp=0", i, rx_valid_a); end
            tick();
        end
        total++; if (rx_valid_a !== 1'b1) begin bad++; $display("FAIL lb_rx_valid got=%b exp=1", rx_valid_a); end
        total++; if (rx_data_a !== 8'hA5) begin bad++; $display("FAIL lb_rx_data got=%h exp=a5", rx_data_a); end
        total++; if (sen_a !== 1'b0) begin bad++; $display("FAIL lb_sen_end got=%b exp=0", sen_a); end
        total++; if (sout_a !== 1'b0) begin bad++; $display("FAIL lb_sout_idle got=%b exp=0", sout_a); end
        tick();
        total++; if (rx_valid_a !== 1'b0) begin bad++; $display("FAIL lb_rx_pulse_width got=%b exp=0", rx_valid_a); end
        total++; if (rx_data_a !== 8'hA5) begin bad++; $display("FAIL lb_rx_hold got=%h exp=a5", rx_data_a); end
    endtask

    task automatic test_back_to_back();
        tx_data_a = 8'h3C;
        tx_valid_a = 1'b1;
        tick();
        tx_data_a = 8'hC3;
        for (int i = 0; i < 16; i++) begin
            total++; if (sen_a !== 1'b1) begin bad++; $display("FAIL b2b_sen cyc%0d got=%b exp=1", i, sen_a); end
            if (i == 6) begin
                total++; if (tx_ready_a !== 1'b0) begin bad++; $display("FAIL b2b_ready_mid got=%b exp=0", tx_ready_a); end
            end
            if (i == 7) begin
                total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL b2b_ready_last got=%b exp=1", tx_ready_a); end
            end
            tick();
            if (i == 7) begin
                total++; if (rx_valid_a !== 1'b1) begin bad++; $display("FAIL b2b_rx_valid1 got=%b exp=1", rx_valid_a); end
                total++; if (rx_data_a !== 8'h3C) begin bad++; $display("FAIL b2b_rx_data1 got=%h exp=3c", rx_data_a); end
                tx_valid_a = 1'b0;
            end else if (i < 15) begin
                total++; if (rx_valid_a !== 1'b0) begin bad++; $display("FAIL b2b_rx_valid_idle cyc%0d got=%b exp=0", i, rx_valid_a); end
            end
        end
        total++; if (rx_valid_a !== 1'b1) begin bad++; $display("FAIL b2b_rx_valid2 got=%b exp=1", rx_valid_a); end
        total++; if (rx_data_a !== 8'hC3) begin bad++; $display("FAIL b2b_rx_data2 got=%h exp=c3", rx_data_a); end
        total++; if (sen_a !== 1'b0) begin bad++; $display("FAIL b2b_sen_end got=%b exp=0", sen_a); end
        tick();
    endtask

    task automatic test_gap();
        tx_data_g = 8'h96;
        tx_valid_g = 1'b1;
        tick();
        tx_data_g = 8'h4B;
        for (int i = 0; i < 8; i++) begin
            total++; if (sen_g !== 1'b1) begin bad++; $display("FAIL gap_sen1 cyc%0d got=%b exp=1", i, sen_g); end
            total++; if (tx_ready_g !== 1'b0) begin bad++; $display("FAIL gap_ready_shift cyc%0d got=%b exp=0", i, tx_ready_g); end
            tick();
        end
        total++; if (rx_valid_g !== 1'b1 || rx_data_g !== 8'h96) begin
            bad++; $display("FAIL gap_rx1 got=%b/%h exp=1/96", rx_valid_g, rx_data_g);
        end
        for (int i = 0; i < 2; i++) begin
            total++; if ({sen_g, tx_ready_g, busy_g} !== 3'b001) begin
                bad++; $display("FAIL gap_hold cyc%0d sen/ready/busy got=%b exp=001", i, {sen_g, tx_ready_g, busy_g});
            end
            tick();
        end
        total++; if ({sen_g, tx_ready_g, busy_g} !== 3'b010) begin
            bad++; $display("FAIL gap_idle sen/ready/busy got=%b exp=010", {sen_g, tx_ready_g, busy_g});
        end
        tick();
        tx_valid_g = 1'b0;
        total++; if (sen_g !== 1'b1 || sout_g !== 1'b0) begin
            bad++; $display("FAIL gap_second_start sen/sout got=%b%b exp=10", sen_g, sout_g);
        end
        for (int i = 0; i < 8; i++) tick();
        total++; if (rx_valid_g !== 1'b1 || rx_data_g !== 8'h4B) begin
            bad++; $display("FAIL gap_rx2 got=%b/%h exp=1/4b", rx_valid_g, rx_data_g);
        end
        for (int i = 0; i < 3; i++) tick();
        total++; if (busy_g !== 1'b0) begin bad++; $display("FAIL gap_final_idle got=%b exp=0", busy_g); end
    endtask

    task automatic test_reset_mid_word();
        tx_data_a = 8'hFF;
        tx_valid_a = 1'b1;
        tick();
        tx_valid_a = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        #1;
        total++; if (sen_a !== 1'b0) begin bad++; $display("FAIL mid_sen got=%b exp=0", sen_a); end
        total++; if (rx_data_a !== 8'h00) begin bad++; $display("FAIL mid_rx_data got=%h exp=00", rx_data_a); end
        total++; if ({busy_a, tx_ready_a} !== 2'b01) begin bad++; $display("FAIL mid_busy_ready got=%b exp=01", {busy_a, tx_ready_a}); end
        for (int i = 0; i < 8; i++) begin
            if (i == 2) reset = 1'b1;
            tick();
            total++; if (rx_valid_a !== 1'b0) begin bad++; $display("FAIL mid_rx_valid cyc%0d got=%b exp=0", i, rx_valid_a); end
        end
        total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b exp=1", tx_ready_a); end
        tx_data_a = 8'h81;
        tx_valid_a = 1'b1;
        tick();
        tx_valid_a = 1'b0;
        total++; if (sout_a !== 1'b1 || sen_a !== 1'b1) begin bad++; $display("FAIL mid_restart_bit0 got=%b%b exp=11", sout_a, sen_a); end
        for (int i = 0; i < 8; i++) tick();
        total++; if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h81) begin
            bad++; $display("FAIL mid_rx_81 got=%b/%h exp=1/81", rx_valid_a, rx_data_a);
        end
        tick();
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_bits;
        int         pulses;
        exp_bits = 8'h01;
        pulses = 0;
        tx_data_l = 8'h01;
        tx_valid_l = 1'b1;
        tick();
        tx_valid_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (sout_l !== exp_bits[i]) begin bad++; $display("FAIL lsb_sout bit%0d got=%b exp=%b", i, sout_l, exp_bits[i]); end
            tick();
            if (rx_valid_l === 1'b1) pulses++;
        end
        total++; if (rx_data_l !== 8'hFF) begin bad++; $display("FAIL lsb_rx_data got=%h exp=ff", rx_data_l); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rx_valid_l === 1'b1) pulses++;
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL lsb_pulse_count got=%0d exp=1", pulses); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        tx_data_a = '0; tx_data_g = '0; tx_data_l = '0;
        tx_valid_a = 1'b0; tx_valid_g = 1'b0; tx_valid_l = 1'b0;
        test_reset();
        test_loopback_msb();
        test_back_to_back();
        test_gap();
        test_reset_mid_word();
        test_lsb_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
